// File: rtl/ecc_176_scrub_ctrl.sv
// Scrub engine and RAM port arbiter for a 176-bit ECC-protected memory.
// Functional requests always own the port; the scrubber walks every address,
// writes back corrected single-bit errors and keeps error statistics.
module ecc_176_scrub_ctrl #(
  parameter int unsigned DATA_WIDTH   = 176,
  parameter int unsigned PARITY_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned INTV_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scrub_en,
  input  logic [INTV_WIDTH-1:0]   scrub_interval,
  input  logic                    cnt_clr,
  input  logic                    func_req,
  input  logic                    func_we,
  input  logic [ADDR_WIDTH-1:0]   func_addr,
  input  logic [DATA_WIDTH-1:0]   func_wdata,
  input  logic [PARITY_WIDTH-1:0] func_wparity,
  output logic                    func_gnt,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [PARITY_WIDTH-1:0] ram_wparity,
  input  logic [DATA_WIDTH-1:0]   ecc_data_out,
  input  logic                    ecc_sbit_err,
  input  logic                    ecc_dbit_err,
  input  logic                    ecc_fault,
  input  logic [PARITY_WIDTH-1:0] enc_parity,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    err_valid,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    pass_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_CHK, S_WB} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_scrub_addr;
  logic [INTV_WIDTH-1:0]   r_wait_cnt;
  logic [CNT_WIDTH-1:0]    r_sbit_cnt;
  logic [CNT_WIDTH-1:0]    r_dbit_cnt;
  logic [CNT_WIDTH-1:0]    r_fault_cnt;
  logic                    r_err_valid;
  logic [ADDR_WIDTH-1:0]   r_err_addr;
  logic                    r_pass_done;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic [PARITY_WIDTH-1:0] r_wb_parity;

  logic w_advance;
  logic w_wb_load;
  logic w_wait_clr;
  logic w_wait_inc;
  logic w_scrub_rd;
  logic w_scrub_wr;
  logic w_sbit_ev;
  logic w_hazard;
  logic w_chk;

  assign w_sbit_ev = ecc_sbit_err & ~ecc_dbit_err & ~ecc_fault;
  assign w_hazard  = func_req & func_we & (func_addr == r_scrub_addr);
  assign w_chk     = (r_state == S_CHK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and scrub control decode
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_wb_load   = 1'b0;
    w_wait_clr  = 1'b0;
    w_wait_inc  = 1'b0;
    w_scrub_rd  = 1'b0;
    w_scrub_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (scrub_en) begin
          w_state_nxt = S_WAIT;
          w_wait_clr  = 1'b1;
        end
      end
      S_WAIT: begin
        if (!scrub_en)                        w_state_nxt = S_IDLE;
        else if (r_wait_cnt == scrub_interval) w_state_nxt = S_RD;
        else                                  w_wait_inc  = 1'b1;
      end
      S_RD: begin
        if (!scrub_en) begin
          w_state_nxt = S_IDLE;
        end else if (!func_req) begin
          w_scrub_rd  = 1'b1;
          w_state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (w_sbit_ev && !w_hazard) begin
          w_wb_load   = 1'b1;
          w_state_nxt = S_WB;
        end else begin
          w_advance   = 1'b1;
          w_wait_clr  = 1'b1;
          w_state_nxt = scrub_en ? S_WAIT : S_IDLE;
        end
      end
      S_WB: begin
        // A colliding functional write makes the corrected data stale: drop it
        if (w_hazard || !func_req) begin
          w_scrub_wr  = ~w_hazard;
          w_advance   = 1'b1;
          w_wait_clr  = 1'b1;
          w_state_nxt = scrub_en ? S_WAIT : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scrub datapath, statistics and error log
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scrub_addr <= '0;
      r_wait_cnt   <= '0;
      r_sbit_cnt   <= '0;
      r_dbit_cnt   <= '0;
      r_fault_cnt  <= '0;
      r_err_valid  <= 1'b0;
      r_err_addr   <= '0;
      r_pass_done  <= 1'b0;
      r_wb_data    <= '0;
      r_wb_parity  <= '0;
    end else begin
      if (w_wait_clr)      r_wait_cnt <= '0;
      else if (w_wait_inc) r_wait_cnt <= r_wait_cnt + INTV_WIDTH'(1);

      r_pass_done <= w_advance && (r_scrub_addr == LAST_ADDR);
      if (w_advance)
        r_scrub_addr <= (r_scrub_addr == LAST_ADDR) ? '0 : r_scrub_addr + ADDR_WIDTH'(1);

      if (w_wb_load) begin
        r_wb_data   <= ecc_data_out;
        r_wb_parity <= enc_parity;
      end

      if (cnt_clr) begin
        r_sbit_cnt  <= '0;
        r_dbit_cnt  <= '0;
        r_fault_cnt <= '0;
        r_err_valid <= 1'b0;
        r_err_addr  <= '0;
      end else if (w_chk) begin
        if (w_sbit_ev && (r_sbit_cnt != '1))
          r_sbit_cnt <= r_sbit_cnt + CNT_WIDTH'(1);
        if (ecc_dbit_err && !ecc_fault && (r_dbit_cnt != '1))
          r_dbit_cnt <= r_dbit_cnt + CNT_WIDTH'(1);
        if (ecc_fault && (r_fault_cnt != '1))
          r_fault_cnt <= r_fault_cnt + CNT_WIDTH'(1);
        if ((ecc_dbit_err || ecc_fault) && !r_err_valid) begin
          r_err_valid <= 1'b1;
          r_err_addr  <= r_scrub_addr;
        end
      end
    end
  end

  // RAM port mux: functional traffic first, scrub silent during reset
  always_comb begin
    func_gnt    = func_req;
    ram_cs      = func_req | ((w_scrub_rd | w_scrub_wr) & ~rst);
    ram_we      = func_req ? func_we : (w_scrub_wr & ~rst);
    ram_addr    = func_req ? func_addr : r_scrub_addr;
    ram_wdata   = func_req ? func_wdata : r_wb_data;
    ram_wparity = func_req ? func_wparity : r_wb_parity;
  end

  assign sbit_cnt  = r_sbit_cnt;
  assign dbit_cnt  = r_dbit_cnt;
  assign fault_cnt = r_fault_cnt;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign pass_done = r_pass_done;

endmodule

// File: doc/ecc_176_scrub_ctrl.md
# ecc_176_scrub_ctrl

Background scrubber and port arbiter for a 176-bit ECC-protected FIFO/RAM. It owns the single RAM port and shares it between the functional requester and a scrub engine. Functional traffic always has top priority. The scrub engine walks every address, checks each word through an external `ecc_176_fault_detc` instance, writes back corrected single-bit errors, and logs error statistics.

## Interface
Parameters:
- DATA_WIDTH, 176, data word width
- PARITY_WIDTH, 9, ECC parity width
- ADDR_WIDTH, 6, RAM address width
- DEPTH, 64, number of words; scrub address wraps at DEPTH-1
- INTV_WIDTH, 16, width of the scrub interval
- CNT_WIDTH, 8, width of the saturating error counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- scrub_en  in  1  enables the scrub engine
- scrub_interval  in  INTV_WIDTH  idle cycles between scrub operations
- cnt_clr  in  1  clears the counters and the error log
- func_req  in  1  functional access request, valid this cycle
- func_we  in  1  1 = write, 0 = read
- func_addr  in  ADDR_WIDTH  functional address
- func_wdata  in  DATA_WIDTH  functional write data
- func_wparity  in  PARITY_WIDTH  functional write parity
- func_gnt  out  1  equals func_req (combinational)
- ram_cs, ram_we  out  1  RAM port strobes; read data arrives 1 cycle later
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_wparity  out  PARITY_WIDTH  RAM write parity
- ecc_data_out  in  DATA_WIDTH  corrected data from the checker, fed from ram_rdata/ram_rparity
- ecc_sbit_err, ecc_dbit_err, ecc_fault  in  1  checker status
- enc_parity  in  PARITY_WIDTH  parity of ecc_data_out, from an external encoder
- sbit_cnt, dbit_cnt, fault_cnt  out  CNT_WIDTH  saturating event counters
- err_valid  out  1  sticky flag: a dbit error or a fault was logged
- err_addr  out  ADDR_WIDTH  address of the first logged dbit error or fault
- pass_done  out  1  one-cycle pulse when a full pass completes

## Operation
- RAM port mux:
  - func_req=1: the RAM port carries the func_* signals.
  - Scrub read: ram_cs=1, ram_we=0, ram_addr=scrub_addr.
  - Scrub writeback: ram_we=1, wdata=ecc_data_out (registered in CHK), wparity=enc_parity (registered in CHK).
  - Otherwise ram_cs=0.
- State machine: IDLE, WAIT, RD, CHK, WB.
- IDLE: go to WAIT when scrub_en=1; wait_cnt is cleared on entry to WAIT.
- WAIT: wait_cnt increments each cycle. Go to RD when wait_cnt==scrub_interval. WAIT therefore lasts scrub_interval+1 cycles.
- RD: the scrub read is issued only if func_req=0 and the engine moves to CHK. Otherwise the engine stays in RD (stall).
- CHK: the read data is valid this cycle.
  - Counters: sbit_cnt++ on sbit&~dbit&~fault; dbit_cnt++ on dbit&~fault; fault_cnt++ on fault.
  - Go to WB only if sbit&~dbit&~fault&~hazard.
  - Otherwise advance scrub_addr and go to WAIT.
- WB: the write is issued when func_req=0; then advance scrub_addr and go to WAIT. While func_req=1 the engine stalls in WB.
- Hazard: a functional write with func_addr==scrub_addr in CHK or in any WB cycle sets the hazard. The hazard cancels the pending writeback: the engine advances without writing. The error count is still kept.
- Address advance:
  - scrub_addr wraps from DEPTH-1 to 0.
  - pass_done pulses in the cycle the wrap is registered.
- scrub_en=0:
  - In IDLE, WAIT or RD: go to IDLE next cycle; no access is issued in that cycle.
  - In CHK or WB: the operation completes (including a stalled WB), then the engine goes to IDLE.
  - scrub_addr is retained while disabled.
- Counters saturate at all-ones.
- Error log: err_addr and err_valid are captured only when err_valid=0, so the first dbit error or fault wins.
- cnt_clr=1 clears the counters, err_valid and err_addr next cycle. If cnt_clr coincides with an increment, the clear wins.
- Reset (rst=1, sampled on clk):
  - state=IDLE; scrub_addr, wait_cnt, all counters, err_valid, err_addr and pass_done = 0.
  - The registered write data and parity are cleared.
  - Reset mid-operation abandons any pending writeback.
- ram_cs/ram_we during reset follow func_req/func_we. The scrub engine issues nothing during reset.

## Timing
- Functional access: 0 added latency; func_gnt is combinational.
- Scrub read path: read issued in cycle N (RD); checker outputs sampled in N+1 (CHK); writeback earliest in N+2.
- Uncontended scrub op: with errors, RD + CHK + WB = 3 cycles; without errors, 2 cycles. Each op is followed by scrub_interval+1 WAIT cycles.
- The engine has only one outstanding read at a time. The functional path never stalls.

## Test plan
- Clean pass, DEPTH=64, interval=0, no func traffic → reads at addresses 0..63, one every 3 cycles (RD, CHK, WAIT); no writes; pass_done pulses once after address 63; all counters stay 0.
- Single-bit error injected at address 5 → WB at addr 5 with corrected data and enc_parity; sbit_cnt=1; a re-read returns ecc_sbit_err=0.
- Double-bit error at address 9, then a fault at address 12 → no WB; dbit_cnt=1, fault_cnt=1; err_valid=1, err_addr=9.
- func_req held 10 cycles during RD, then during WB → scrub stalls exactly 10 cycles each time; func_gnt=1 throughout; no lost or duplicated scrub access.
- Sbit error at address 20 plus a functional write to address 20 while WB is stalled → no scrub write to 20; sbit_cnt=1; addr advances to 21.
- Counter saturation at 255; cnt_clr coincident with an increment → counters 0; rst asserted in WB → no write, all outputs 0 next cycle.
